// File: rtl/aib_bsr_red_chain_pkg.sv
// Shared definitions for the AIB boundary-scan / redundancy column:
// per-pad cell offsets in the scan chain, repair FSM states and the
// quiet-counter width helper.
package aib_bsr_red_pkg;

  // Position of each cell inside one pad's 4-bit slice (bit 0 is nearest scan-out)
  localparam int CELL_TXEN    = 0;
  localparam int CELL_D0      = 1;
  localparam int CELL_D1      = 2;
  localparam int CELL_RX      = 3;
  localparam int CELLS_PER_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } red_state_t;

  // The quiet counter runs 0..quiet_cyc-1; never narrower than one bit
  function automatic int quiet_cnt_w(input int quiet_cyc);
    return (quiet_cyc <= 2) ? 1 : $clog2(quiet_cyc);
  endfunction

endpackage

// File: rtl/aib_bsr_red_chain_if.sv
// Redundancy configuration and pad/adapter data bundle for one AIB column.
//
// Handshake: red_cfg_load is a single-cycle request that the block samples
// only while red_cfg_busy is low. An accepted request raises red_cfg_busy on
// the following edge; red_cfg_busy falling means the new steering is applied
// and the pads are released. Requests made while busy are dropped, not queued.
interface aib_bsr_red_chain_if #(
  parameter int NUM_CH = 16,
  parameter int RIDX_W = $clog2(NUM_CH)
) ();

  logic                    red_cfg_load;
  logic [RIDX_W-1:0]       red_cfg_idx;
  logic                    red_cfg_busy;
  logic [NUM_CH-1:0]       shift_en;
  logic [3*(NUM_CH-1)-1:0] adap_tx;
  logic [3*NUM_CH-1:0]     aib_tx;
  logic [NUM_CH-1:0]       aib_rx;
  logic [NUM_CH-2:0]       adap_rx;

  // Firmware / adapter / pad environment side
  modport master (
    output red_cfg_load, red_cfg_idx, adap_tx, aib_rx,
    input  red_cfg_busy, shift_en, aib_tx, adap_rx
  );

  // Repair and boundary-scan block side
  modport slave (
    input  red_cfg_load, red_cfg_idx, adap_tx, aib_rx,
    output red_cfg_busy, shift_en, aib_tx, adap_rx
  );

endinterface

// File: rtl/aib_bsr_red_chain_cell.sv
// One pad's boundary-scan slice: four shift cells (txen, d0, d1, rx), their
// update latches and the functional/JTAG mux for the pad TX fields.
module aib_bsr_red_cell
  import aib_bsr_red_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       capture,
  input  logic       shift,
  input  logic       update,
  input  logic       mode,
  input  logic       scan_in,
  input  logic [2:0] func_tx,   // {txen, d1, d0} after steering and quiet force
  input  logic       pad_rx,
  output logic       scan_out,
  output logic [2:0] pad_tx,    // {txen, d1, d0} driven to the pad
  output logic       upd_rx
);

  logic [CELLS_PER_CH-1:0] sr_q;
  logic [CELLS_PER_CH-1:0] upd_q;

  // Shift slice: capture outranks shift; shifting moves toward cell 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (capture) begin
      sr_q[CELL_TXEN] <= func_tx[2];
      sr_q[CELL_D0]   <= func_tx[0];
      sr_q[CELL_D1]   <= func_tx[1];
      sr_q[CELL_RX]   <= pad_rx;
    end else if (shift) begin
      sr_q <= {scan_in, sr_q[CELLS_PER_CH-1:1]};
    end
  end

  // Update slice copies the pre-edge shift contents, independent of capture/shift
  always_ff @(posedge clk) begin
    if (rst) begin
      upd_q <= '0;
    end else if (update) begin
      upd_q <= sr_q;
    end
  end

  assign scan_out = sr_q[CELL_TXEN];
  assign upd_rx   = upd_q[CELL_RX];
  assign pad_tx   = mode ? {upd_q[CELL_TXEN], upd_q[CELL_D1], upd_q[CELL_D0]}
                         : func_tx;

endmodule

// File: rtl/aib_bsr_red_chain.sv
// Column of NUM_CH AIB pads (last one spare): lane-to-pad steering around a
// repaired pad, glitch-free repair sequencing (drain / switch / settle) and
// the pad-major boundary-scan chain.
// Optional build macro: AIB_BSR_INTEST_EN adds jtag_intest, which lets the
// update register's rx cells drive adap_rx while in JTAG mode.
module aib_bsr_red_chain
  import aib_bsr_red_pkg::*;
#(
  parameter int NUM_CH    = 16,
  parameter int QUIET_CYC = 4,
  parameter int RIDX_W    = $clog2(NUM_CH)
) (
  input  logic              jtag_clkdr_in,
  input  logic              jtag_rst,
  input  logic              jtag_capture,
  input  logic              jtag_tx_scanen_in,
  input  logic              jtag_update,
  input  logic              jtag_tx_scan_in,
  output logic              jtag_rx_scan_out,
  input  logic              jtag_mode_in,
`ifdef AIB_BSR_INTEST_EN
  input  logic              jtag_intest,
`endif
  aib_bsr_red_chain_if.slave bus,
  output red_state_t        dbg_state,
  output logic [RIDX_W-1:0] dbg_ridx
);

  localparam int                CNT_W     = quiet_cnt_w(QUIET_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(QUIET_CYC - 1);
  localparam logic [RIDX_W-1:0] NO_REPAIR = RIDX_W'(NUM_CH - 1);

  red_state_t          state_q;
  logic                busy_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [RIDX_W-1:0]   ridx_q;
  logic [RIDX_W-1:0]   pend_idx_q;
  logic [RIDX_W-1:0]   load_idx;

  logic [3*NUM_CH-1:0] func_tx;
  logic [3*NUM_CH-1:0] pad_tx;
  logic [NUM_CH-1:0]   shift_en_c;
  logic [NUM_CH-2:0]   adap_rx_c;
  logic [NUM_CH-1:0]   upd_rx;
  logic [NUM_CH-1:0]   rx_src;
  logic [NUM_CH-1:0]   so_vec;
  logic [NUM_CH-1:0]   si_vec;
  logic                intest_sel;

  // Out-of-range indices mean "no repair" (the spare pad)
  assign load_idx = (32'(bus.red_cfg_idx) > NUM_CH - 1) ? NO_REPAIR : bus.red_cfg_idx;

  // Repair sequencer: pads are held quiet around the one-cycle steering switch
  always_ff @(posedge jtag_clkdr_in) begin
    if (jtag_rst) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      ridx_q     <= '0;
      pend_idx_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.red_cfg_load) begin
            pend_idx_q <= load_idx;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_SWITCH;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_SWITCH: begin
          ridx_q  <= pend_idx_q;
          state_q <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Steering: lanes below ridx go straight, the rest skip the repaired pad.
  // txen stays low for the whole busy window, SWITCH included, so the pads
  // never see the old and new steering with drivers enabled.
  always_comb begin
    func_tx = '0;
    for (int i = 0; i < NUM_CH - 1; i++) begin
      if (i < int'(ridx_q)) func_tx[3*i +: 3] = bus.adap_tx[3*i +: 3];
      else                  func_tx[3*(i+1) +: 3] = bus.adap_tx[3*i +: 3];
    end
    if (busy_q) begin
      for (int p = 0; p < NUM_CH; p++) func_tx[3*p+2] = 1'b0;
    end
  end

`ifdef AIB_BSR_INTEST_EN
  assign intest_sel = jtag_intest & jtag_mode_in;
`else
  assign intest_sel = 1'b0;
`endif

  assign rx_src = intest_sel ? upd_rx : bus.aib_rx;

  // Receive steering and per-pad shift selects follow the applied ridx
  always_comb begin
    shift_en_c = '0;
    adap_rx_c  = '0;
    for (int p = 0; p < NUM_CH; p++) shift_en_c[p] = (p > int'(ridx_q));
    for (int i = 0; i < NUM_CH - 1; i++) begin
      adap_rx_c[i] = (i < int'(ridx_q)) ? rx_src[i] : rx_src[i+1];
    end
  end

  // Chain is pad-major: pad NUM_CH-1 is fed from scan-in, pad 0 drives scan-out
  assign si_vec = {jtag_tx_scan_in, so_vec[NUM_CH-1:1]};

  for (genvar p = 0; p < NUM_CH; p++) begin : g_cell
    aib_bsr_red_cell u_cell (
      .clk      (jtag_clkdr_in),
      .rst      (jtag_rst),
      .capture  (jtag_capture),
      .shift    (jtag_tx_scanen_in),
      .update   (jtag_update),
      .mode     (jtag_mode_in),
      .scan_in  (si_vec[p]),
      .func_tx  (func_tx[3*p +: 3]),
      .pad_rx   (bus.aib_rx[p]),
      .scan_out (so_vec[p]),
      .pad_tx   (pad_tx[3*p +: 3]),
      .upd_rx   (upd_rx[p])
    );
  end

  assign jtag_rx_scan_out = so_vec[0];
  assign bus.aib_tx       = pad_tx;
  assign bus.adap_rx      = adap_rx_c;
  assign bus.shift_en     = shift_en_c;
  assign bus.red_cfg_busy = busy_q;
  assign dbg_state        = state_q;
  assign dbg_ridx         = ridx_q;

endmodule

// File: tb/tb_aib_bsr_red_chain.sv
// Directed bench for aib_bsr_red_chain: steering vectors, repair sequencing,
// scan capture/shift/update and reset abort.
module tb_aib_bsr_red_chain;
  import aib_bsr_red_pkg::*;

  localparam int NUM_CH    = 16;
  localparam int QUIET_CYC = 4;
  localparam int RIDX_W    = 4;
  localparam int NL        = NUM_CH - 1;
  localparam int BUSY_CYC  = 2 * QUIET_CYC + 1;
  localparam int NVEC      = 7;

  logic clk;
  logic jtag_rst;
  logic jtag_capture;
  logic jtag_tx_scanen_in;
  logic jtag_update;
  logic jtag_tx_scan_in;
  logic jtag_rx_scan_out;
  logic jtag_mode_in;
`ifdef AIB_BSR_INTEST_EN
  logic jtag_intest;
`endif
  red_state_t        dbg_state;
  logic [RIDX_W-1:0] dbg_ridx;

  aib_bsr_red_chain_if #(.NUM_CH(NUM_CH), .RIDX_W(RIDX_W)) bus ();

  aib_bsr_red_chain #(.NUM_CH(NUM_CH), .QUIET_CYC(QUIET_CYC), .RIDX_W(RIDX_W)) dut (
    .jtag_clkdr_in     (clk),
    .jtag_rst          (jtag_rst),
    .jtag_capture      (jtag_capture),
    .jtag_tx_scanen_in (jtag_tx_scanen_in),
    .jtag_update       (jtag_update),
    .jtag_tx_scan_in   (jtag_tx_scan_in),
    .jtag_rx_scan_out  (jtag_rx_scan_out),
    .jtag_mode_in      (jtag_mode_in),
`ifdef AIB_BSR_INTEST_EN
    .jtag_intest       (jtag_intest),
`endif
    .bus               (bus),
    .dbg_state         (dbg_state),
    .dbg_ridx          (dbg_ridx)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one repair load and watch the busy window
  task automatic do_repair(input logic [RIDX_W-1:0] idx, output int n_busy,
                           output logic [NUM_CH-1:0] se_sw, output logic [NUM_CH-1:0] se_st,
                           output int txen_leak);
    logic got_st;
    bus.red_cfg_idx  = idx;
    bus.red_cfg_load = 1'b1;
    tick();
    bus.red_cfg_load = 1'b0;
    #1;
    n_busy = 0; txen_leak = 0; se_sw = '0; se_st = '0; got_st = 1'b0;
    while (bus.red_cfg_busy === 1'b1 && n_busy < 100) begin
      n_busy++;
      if (dbg_state == ST_SWITCH) se_sw = bus.shift_en;
      if (dbg_state == ST_SETTLE && !got_st) begin
        se_st  = bus.shift_en;
        got_st = 1'b1;
      end
      for (int p = 0; p < NUM_CH; p++) if (bus.aib_tx[3*p+2] !== 1'b0) txen_leak++;
      tick();
      #1;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.red_cfg_busy !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 64'(n < 100), 64'd1);
  endtask

  // Expected captured chain for all-ones adap_tx, given rx pattern and repaired pad
  task automatic load_capture_exp(input logic [NUM_CH-1:0] rx, input int rpad);
    exp_q.delete();
    for (int p = 0; p < NUM_CH; p++) begin
      for (int c = 0; c < CELLS_PER_CH; c++) begin
        if (c == CELL_RX) exp_q.push_back(rx[p]);
        else              exp_q.push_back((p != rpad) ? 1'b1 : 1'b0);
      end
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [RIDX_W-1:0] ridx;
    int                lane;
    int                exp_pad;
    logic [NUM_CH-1:0] rx;
    logic [NL-1:0]     exp_arx;
    logic [NUM_CH-1:0] exp_se;
  } vec_t;

  vec_t vecs[NVEC];

  initial begin
    int                nb, leak;
    logic [NUM_CH-1:0] sw, st;
    logic [3*NUM_CH-1:0] exp_tx;
    logic [63:0]       shift_pat;
    logic [NUM_CH-1:0] rx_seen;
    logic [NL-1:0]     exp_arx;
    logic [0:0]        e;
    int                q, n;

    vecs[0] = '{4'd15, 3,  3,  16'h0008, 15'h0008, 16'h0000};
    vecs[1] = '{4'd5,  4,  4,  16'h0040, 15'h0020, 16'hFFC0};
    vecs[2] = '{4'd5,  5,  6,  16'h0020, 15'h0000, 16'hFFC0};
    vecs[3] = '{4'd0,  0,  1,  16'h8000, 15'h4000, 16'hFFFE};
    vecs[4] = '{4'd15, 14, 14, 16'h8000, 15'h0000, 16'h0000};
    vecs[5] = '{4'd8,  7,  7,  16'h0080, 15'h0080, 16'hFE00};
    vecs[6] = '{4'd8,  8,  9,  16'h0200, 15'h0100, 16'hFE00};
    shift_pat = 64'hDEAD_BEEF_1234_5678;

    jtag_rst = 1'b1; jtag_capture = 1'b0; jtag_tx_scanen_in = 1'b0; jtag_update = 1'b0;
    jtag_tx_scan_in = 1'b0; jtag_mode_in = 1'b0;
`ifdef AIB_BSR_INTEST_EN
    jtag_intest = 1'b0;
`endif
    bus.red_cfg_load = 1'b0; bus.red_cfg_idx = '0;
    bus.adap_tx = '1; bus.aib_rx = '0;

    // Reset state, sampled while reset is held
    repeat (3) tick();
    #1;
    check("rst_busy", 64'(bus.red_cfg_busy), 64'd0);
    check("rst_scan_out", 64'(jtag_rx_scan_out), 64'd0);
    check("rst_shift_en", 64'(bus.shift_en), 64'hFFFE);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rst_ridx", 64'(dbg_ridx), 64'd0);
    check("rst_aib_tx", 64'(bus.aib_tx), 64'hFFFF_FFFF_FFF8);
    jtag_rst = 1'b0;
    tick();

    // Test 1: first load after reset, no repair
    do_repair(4'd15, nb, sw, st, leak);
    check("t1_busy_len", 64'(nb), 64'(BUSY_CYC));
    check("t1_se_in_switch", 64'(sw), 64'hFFFE);
    check("t1_se_after_switch", 64'(st), 64'h0000);
    check("t1_txen_quiet", 64'(leak), 64'd0);
    check("t1_aib_tx", 64'(bus.aib_tx), 64'h1FFF_FFFF_FFFF);

    // Test 2: repair pad 5 with every lane enabled
    do_repair(4'd5, nb, sw, st, leak);
    check("t2_busy_len", 64'(nb), 64'(BUSY_CYC));
    check("t2_txen_quiet", 64'(leak), 64'd0);
    check("t2_aib_tx", 64'(bus.aib_tx), 64'hFFFF_FFFC_7FFF);
    bus.aib_rx = 16'h0040;
    #1;
    check("t2_adap_rx5", 64'(bus.adap_rx[5]), 64'd1);

    // Steering vectors: one live lane and one live rx pad per row
    for (int v = 0; v < NVEC; v++) begin
      bus.adap_tx = '1;
      do_repair(vecs[v].ridx, nb, sw, st, leak);
      check($sformatf("vec%0d_busy_len", v), 64'(nb), 64'(BUSY_CYC));
      bus.adap_tx = '0;
      bus.adap_tx[3*vecs[v].lane +: 3] = 3'b111;
      bus.aib_rx = vecs[v].rx;
      #1;
      exp_tx = '0;
      exp_tx[3*vecs[v].exp_pad +: 3] = 3'b111;
      check($sformatf("vec%0d_aib_tx", v), 64'(bus.aib_tx), 64'(exp_tx));
      check($sformatf("vec%0d_adap_rx", v), 64'(bus.adap_rx), 64'(vecs[v].exp_arx));
      check($sformatf("vec%0d_shift_en", v), 64'(bus.shift_en), 64'(vecs[v].exp_se));
    end

    // Test 3: second load during DRAIN is dropped
    bus.red_cfg_idx = 4'd5; bus.red_cfg_load = 1'b1;
    tick();
    bus.red_cfg_load = 1'b0;
    #1;
    check("t3_in_drain", 64'(dbg_state), 64'(ST_DRAIN));
    tick();
    bus.red_cfg_idx = 4'd7; bus.red_cfg_load = 1'b1;
    tick();
    bus.red_cfg_load = 1'b0;
    wait_idle("t3_idle_timeout");
    #1;
    check("t3_ridx", 64'(dbg_ridx), 64'd5);
    check("t3_shift_en", 64'(bus.shift_en), 64'hFFC0);
    tick();
    #1;
    check("t3_no_requeue", 64'(bus.red_cfg_busy), 64'd0);

    // Test 4: capture then shift the whole chain out
    bus.adap_tx = '1; bus.aib_rx = 16'hA5A5;
    jtag_capture = 1'b1;
    tick();
    jtag_capture = 1'b0; jtag_tx_scanen_in = 1'b1;
    load_capture_exp(16'hA5A5, 5);
    rx_seen = '0;
    for (int k = 0; k < CELLS_PER_CH * NUM_CH; k++) begin
      jtag_tx_scan_in = shift_pat[k];
      #1;
      e = exp_q.pop_front();
      check($sformatf("t4_scan_bit%0d", k), 64'(jtag_rx_scan_out), 64'(e));
      if (k % CELLS_PER_CH == CELL_RX) rx_seen[k / CELLS_PER_CH] = jtag_rx_scan_out;
      tick();
    end
    jtag_tx_scanen_in = 1'b0;
    check("t4_rx_stream", 64'(rx_seen), 64'hA5A5);

    // Test 5: capture+shift+update in one cycle, then JTAG drives the pads
    jtag_mode_in = 1'b1;
    #1;
    check("t5_aib_tx_upd_zero", 64'(bus.aib_tx), 64'd0);
    jtag_capture = 1'b1; jtag_tx_scanen_in = 1'b1; jtag_update = 1'b1;
    tick();
    jtag_capture = 1'b0; jtag_update = 1'b0;
    #1;
    exp_tx = '0;
    for (int p = 0; p < NUM_CH; p++) begin
      exp_tx[3*p+2] = shift_pat[4*p+CELL_TXEN];
      exp_tx[3*p+1] = shift_pat[4*p+CELL_D1];
      exp_tx[3*p]   = shift_pat[4*p+CELL_D0];
    end
    check("t5_aib_tx_from_upd", 64'(bus.aib_tx), 64'(exp_tx));
    load_capture_exp(16'hA5A5, 5);
    jtag_tx_scan_in = 1'b1;
    for (int k = 0; k < CELLS_PER_CH * NUM_CH; k++) begin
      #1;
      e = exp_q.pop_front();
      check($sformatf("t5_capture_won_bit%0d", k), 64'(jtag_rx_scan_out), 64'(e));
      tick();
    end
    jtag_tx_scanen_in = 1'b0;
    #1;
    check("t5_aib_tx_held", 64'(bus.aib_tx), 64'(exp_tx));

    // Receive path in JTAG mode: pads, or update rx cells when intest is set
    exp_arx = '0;
    for (int i = 0; i < NL; i++) begin
      q = (i < 5) ? i : i + 1;
      exp_arx[i] = bus.aib_rx[q];
    end
    check("t5_adap_rx_pads", 64'(bus.adap_rx), 64'(exp_arx));
`ifdef AIB_BSR_INTEST_EN
    jtag_intest = 1'b1;
    #1;
    exp_arx = '0;
    for (int i = 0; i < NL; i++) begin
      q = (i < 5) ? i : i + 1;
      exp_arx[i] = shift_pat[4*q+CELL_RX];
    end
    check("intest_adap_rx", 64'(bus.adap_rx), 64'(exp_arx));
    jtag_intest = 1'b0;
`endif
    jtag_mode_in = 1'b0;

    // Test 6: reset during SETTLE aborts the sequence
    bus.red_cfg_idx = 4'd9; bus.red_cfg_load = 1'b1;
    tick();
    bus.red_cfg_load = 1'b0;
    n = 0;
    while (dbg_state != ST_SETTLE && n < 50) begin
      tick();
      n++;
    end
    check("t6_reach_settle", 64'(n < 50), 64'd1);
    check("t6_scan_out_pre", 64'(jtag_rx_scan_out), 64'd1);
    jtag_rst = 1'b1;
    tick();
    #1;
    check("t6_state", 64'(dbg_state), 64'(ST_IDLE));
    check("t6_busy", 64'(bus.red_cfg_busy), 64'd0);
    check("t6_ridx", 64'(dbg_ridx), 64'd0);
    check("t6_shift_en", 64'(bus.shift_en), 64'hFFFE);
    check("t6_scan_out", 64'(jtag_rx_scan_out), 64'd0);
    jtag_rst = 1'b0;
    tick();
    tick();
    #1;
    check("t6_no_resume", 64'(bus.red_cfg_busy), 64'd0);
    check("t6_ridx_held", 64'(dbg_ridx), 64'd0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
